alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered accumulator ALU for the next-generation lab CPU; successor to the 8-bit single-cycle ALU.
//  Adds a WIDTH parameter, carry/zero flags, subtract/OR/shift ops and an iterative shift-add multiplier.
//  Uses a valid/ready issue handshake so the controller can stall on multi-cycle ops.
//  Sits between the accumulator register and the data bus; output feeds the accumulator load path.
// PARAMETERS
//  WIDTH    8   datapath width of accum, data and out (>=4)
//  CNT_W    $clog2(WIDTH)+1   multiplier iteration counter width (derived; do not override)
// PORTS
//  clk        in   1      clock; all state updates on negedge clk (same CPU timing as current ALU)
//  rst_       in   1      asynchronous, active-low reset
//  in_valid   in   1      opcode/operands valid this cycle
//  in_ready   out  1      ALU can accept an op; issue = in_valid & in_ready
//  opcode     in   alu_op_t  operation (typedefs package)
//  accum      in   WIDTH  accumulator operand
//  data       in   WIDTH  memory/immediate operand
//  out        out  WIDTH  registered result
//  zero       out  1      accum==0, sampled at issue (drives SKZ)
//  carry      out  1      carry/borrow/shift-out/MUL-overflow of last completed op
//  out_valid  out  1      one-cycle pulse: out/carry updated this cycle
//  busy       out  1      multi-cycle op in progress
// BEHAVIOUR
//  Reset (async, rst_ low): out='0, zero=0, carry=0, out_valid=0, busy=0, in_ready=1, FSM=IDLE, counter=0.
//  in_ready = (state==IDLE). in_valid with in_ready low: ignored; upstream holds the op.
//  Single-cycle ops, accepted at negedge N -> out/carry/out_valid at negedge N (latency 1 edge):
//   HLT,SKZ,STO,JMP: out=accum, carry=0 | LDA: out=data, carry=0
//   ADD: {carry,out}=accum+data (WIDTH+1 bits) | SUB: {borrow,out}=accum-data, carry=borrow
//   AND/OR/XOR: bitwise, carry=0 | SHL: out=accum<<1, carry=accum[WIDTH-1] | SHR: out=accum>>1, carry=accum[0]
//   Any undefined encoding: out='0, carry=0, out_valid=1.
//  zero updates on every issue (all opcodes) from accum, never from the result.
//  out/carry hold their value between completions; out_valid is low except on a completion edge.
//  MUL FSM (present only with ALU_MUL_EN):
//   IDLE --issue MUL--> MUL: latch multiplicand=accum, multiplier=data, product='0, cnt=0, busy=1
//   MUL: each edge, if multiplier[0] product+=multiplicand<<cnt; multiplier>>=1; cnt++;
//        after WIDTH iterations -> DONE
//   DONE (1 edge): out=product[WIDTH-1:0], carry=|product[2*WIDTH-1:WIDTH], out_valid=1, busy=0 -> IDLE
//   Latency: issue edge + WIDTH + 1 edges; in_ready low from the edge after issue until DONE returns to IDLE.
//   Multiplier==0 still takes the full WIDTH iterations (fixed latency).
//  Reset mid-MUL: abort; all outputs and FSM to reset values, partial product discarded, no out_valid.
//  Back-to-back single-cycle ops: one per edge, in_ready stays 1.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL opcode uses the FSM above; busy usable.
//  ALU_MUL_EN undefined: no FSM/counter logic; busy tied 0, in_ready tied 1;
//   MUL is treated as an undefined encoding (out='0, carry=0, out_valid=1).
// STRUCTURE
//  typedefs package: alu_op_t (4-bit enum) = HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP (existing codes 0-7 unchanged),
//   SUB=8, OR=9, SHL=10, SHR=11, MUL=12; alu_state_t = IDLE,MUL,DONE.
//  One sub-module: alu_mul_iter (shift-add engine: start, operands, product, done);
//   instantiated only under ALU_MUL_EN. Flag/opcode decode stays in alu_pipe.
// TESTING (WIDTH=8 unless noted)
//  1 Reset: rst_=0 mid-stream -> out=00, carry=0, zero=0, out_valid=0, in_ready=1 without waiting for a clock edge.
//  2 ADD accum=F0,data=20 -> out=10, carry=1, out_valid pulse 1 edge; SUB accum=05,data=06 -> out=FF, carry=1.
//  3 zero flag: LDA with accum=00,data=55 -> zero=1, out=55; then XOR accum=55,data=55 -> out=00, zero=0.
//  4 SHL accum=81 -> out=02, carry=1; SHR accum=81 -> out=40, carry=1; undefined opcode 15 -> out=00, out_valid=1.
//  5 ALU_MUL_EN: MUL 0C*0B -> in_ready low 9 edges, out=84, carry=0; MUL FF*02 -> out=FE, carry=1;
//    in_valid held during busy is not accepted.
//  6 ALU_MUL_EN: rst_ low 3 edges into MUL -> no out_valid, state IDLE; without ALU_MUL_EN MUL -> out=00, 1-edge latency.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode and FSM state typedefs for the accumulator ALU
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_HLT = 4'd0,
        OP_SKZ = 4'd1,
        OP_ADD = 4'd2,
        OP_AND = 4'd3,
        OP_XOR = 4'd4,
        OP_LDA = 4'd5,
        OP_STO = 4'd6,
        OP_JMP = 4'd7,
        OP_SUB = 4'd8,
        OP_OR  = 4'd9,
        OP_SHL = 4'd10,
        OP_SHR = 4'd11,
        OP_MUL = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue handshake and result bus between controller and ALU
interface alu_pipe_if #(parameter int WIDTH = 8);
    import alu_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_t          opcode;
    logic [WIDTH-1:0] accum;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, opcode, accum, data,
        input  in_ready, out, zero, carry, out_valid, busy
    );

    modport slave (
        input  in_valid, opcode, accum, data,
        output in_ready, out, zero, carry, out_valid, busy
    );

endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier engine, one partial product per negedge
module alu_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start,
    input  logic               run,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    // multiplicand is pre-shifted each step, equivalent to adding mcand << cnt
    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
            prod_q   <= '0;
            mplier_q <= multiplier;
            cnt_q    <= '0;
        end else if (run) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // done flags the edge on which the final iteration is taken
    assign done    = run && (cnt_q == LAST);
    assign product = prod_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered accumulator ALU; MUL FSM present only when ALU_MUL_EN is defined
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_,
    alu_pipe_if.slave bus
);

    logic             issue;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic [WIDTH-1:0] out_q, out_nxt;
    logic             carry_q, carry_nxt;
    logic             zero_q, zero_nxt;
    logic             valid_q, valid_nxt;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_state_t         state_q, state_nxt;
    logic               mul_start;
    logic               mul_run;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk          (clk),
        .rst_         (rst_),
        .start        (mul_start),
        .run          (mul_run),
        .multiplicand (bus.accum),
        .multiplier   (bus.data),
        .product      (product),
        .done         (mul_done)
    );

    assign mul_run      = (state_q == ST_MUL);
    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end
`else
    assign bus.in_ready = 1'b1;
    assign bus.busy     = 1'b0;
`endif

    assign issue = bus.in_valid & bus.in_ready;

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        case (bus.opcode)
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: sc_res = bus.accum;
            OP_LDA: sc_res = bus.data;
            OP_ADD: {sc_carry, sc_res} = {1'b0, bus.accum} + {1'b0, bus.data};
            OP_SUB: {sc_carry, sc_res} = {1'b0, bus.accum} - {1'b0, bus.data};
            OP_AND: sc_res = bus.accum & bus.data;
            OP_OR:  sc_res = bus.accum | bus.data;
            OP_XOR: sc_res = bus.accum ^ bus.data;
            OP_SHL: {sc_carry, sc_res} = {bus.accum, 1'b0};
            OP_SHR: {sc_res, sc_carry} = {1'b0, bus.accum};
            default: begin
                sc_res   = '0;
                sc_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_nxt   = out_q;
        carry_nxt = carry_q;
        zero_nxt  = zero_q;
        valid_nxt = 1'b0;
        // zero reflects the accumulator operand at issue, not the result
        if (issue) zero_nxt = (bus.accum == '0);
`ifdef ALU_MUL_EN
        state_nxt = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue && bus.opcode == OP_MUL) begin
                    mul_start = 1'b1;
                    state_nxt = ST_MUL;
                end else if (issue) begin
                    out_nxt   = sc_res;
                    carry_nxt = sc_carry;
                    valid_nxt = 1'b1;
                end
            end
            ST_MUL: if (mul_done) state_nxt = ST_DONE;
            ST_DONE: begin
                out_nxt   = product[WIDTH-1:0];
                carry_nxt = |product[2*WIDTH-1:WIDTH];
                valid_nxt = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
`else
        if (issue) begin
            out_nxt   = sc_res;
            carry_nxt = sc_carry;
            valid_nxt = 1'b1;
        end
`endif
    end

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_nxt;
            carry_q <= carry_nxt;
            zero_q  <= zero_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign bus.out       = out_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (WIDTH=8), with or without ALU_MUL_EN
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic clk  = 1'b0;
    logic rst_ = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_pipe_if #(.WIDTH(8)) bus ();

    alu_pipe #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // present an op before the negedge, leave outputs settled 1 ns after it
    task automatic do_op(input alu_op_t op, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.accum    = a;
        bus.data     = d;
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.opcode   = OP_HLT;
        bus.accum    = 8'h00;
        bus.data     = 8'h00;
        #1 rst_ = 1'b0;
        #1;
        n_tests++; if (bus.out !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h exp 00", bus.out); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        @(posedge clk);
        rst_ = 1'b1;
        // make state non-trivial, then reset between edges
        do_op(OP_ADD, 8'hF0, 8'h20);
        do_op(OP_LDA, 8'h00, 8'h33);
        rst_ = 1'b0;
        #1;
        n_tests++; if (bus.out !== 8'h00) begin n_fail++; $display("FAIL midreset_out got %h exp 00", bus.out); end
        n_tests++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL midreset_zero got %b exp 0", bus.zero); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_ready_busy got %b/%b exp 1/0", bus.in_ready, bus.busy); end
        @(posedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_add_sub();
        do_op(OP_ADD, 8'hF0, 8'h20);
        n_tests++; if (bus.out !== 8'h10 || bus.carry !== 1'b1) begin n_fail++; $display("FAIL add got %h/%b exp 10/1", bus.out, bus.carry); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
        @(negedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_pulse got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.out !== 8'h10 || bus.carry !== 1'b1) begin n_fail++; $display("FAIL add_hold got %h/%b exp 10/1", bus.out, bus.carry); end
        do_op(OP_ADD, 8'h12, 8'h34);
        n_tests++; if (bus.out !== 8'h46 || bus.carry !== 1'b0) begin n_fail++; $display("FAIL add_nc got %h/%b exp 46/0", bus.out, bus.carry); end
        do_op(OP_SUB, 8'h05, 8'h06);
        n_tests++; if (bus.out !== 8'hFF || bus.carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow got %h/%b exp FF/1", bus.out, bus.carry); end
        do_op(OP_SUB, 8'h40, 8'h01);
        n_tests++; if (bus.out !== 8'h3F || bus.carry !== 1'b0) begin n_fail++; $display("FAIL sub got %h/%b exp 3F/0", bus.out, bus.carry); end
    endtask

    task automatic test_zero();
        do_op(OP_LDA, 8'h00, 8'h55);
        n_tests++; if (bus.zero !== 1'b1 || bus.out !== 8'h55) begin n_fail++; $display("FAIL lda_zero got %b/%h exp 1/55", bus.zero, bus.out); end
        do_op(OP_XOR, 8'h55, 8'h55);
        n_tests++; if (bus.zero !== 1'b0 || bus.out !== 8'h00) begin n_fail++; $display("FAIL xor_zero got %b/%h exp 0/00", bus.zero, bus.out); end
        do_op(OP_SKZ, 8'h00, 8'h99);
        n_tests++; if (bus.zero !== 1'b1 || bus.out !== 8'h00 || bus.carry !== 1'b0) begin n_fail++; $display("FAIL skz got %b/%h/%b exp 1/00/0", bus.zero, bus.out, bus.carry); end
        do_op(OP_STO, 8'hA7, 8'h00);
        n_tests++; if (bus.zero !== 1'b0 || bus.out !== 8'hA7) begin n_fail++; $display("FAIL sto got %b/%h exp 0/A7", bus.zero, bus.out); end
    endtask

    task automatic test_logic_shift();
        alu_op_t bad;
        do_op(OP_AND, 8'hF0, 8'h3C);
        n_tests++; if (bus.out !== 8'h30) begin n_fail++; $display("FAIL and got %h exp 30", bus.out); end
        do_op(OP_OR, 8'hF0, 8'h0F);
        n_tests++; if (bus.out !== 8'hFF || bus.carry !== 1'b0) begin n_fail++; $display("FAIL or got %h/%b exp FF/0", bus.out, bus.carry); end
        do_op(OP_SHL, 8'h81, 8'h00);
        n_tests++; if (bus.out !== 8'h02 || bus.carry !== 1'b1) begin n_fail++; $display("FAIL shl got %h/%b exp 02/1", bus.out, bus.carry); end
        do_op(OP_SHR, 8'h81, 8'h00);
        n_tests++; if (bus.out !== 8'h40 || bus.carry !== 1'b1) begin n_fail++; $display("FAIL shr got %h/%b exp 40/1", bus.out, bus.carry); end
        bad = alu_op_t'(4'hF);
        do_op(bad, 8'h77, 8'h11);
        n_tests++; if (bus.out !== 8'h00 || bus.carry !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL undef got %h/%b/%b exp 00/0/1", bus.out, bus.carry, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        bus.in_valid = 1'b1; bus.opcode = OP_ADD; bus.accum = 8'h01; bus.data = 8'h02;
        @(negedge clk); #1;
        n_tests++; if (bus.out !== 8'h03 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_0 got %h/%b/%b exp 03/1/1", bus.out, bus.out_valid, bus.in_ready); end
        bus.opcode = OP_SUB; bus.accum = 8'h10; bus.data = 8'h01;
        @(negedge clk); #1;
        n_tests++; if (bus.out !== 8'h0F || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_1 got %h/%b/%b exp 0F/1/1", bus.out, bus.out_valid, bus.in_ready); end
        bus.opcode = OP_JMP; bus.accum = 8'hC3; bus.data = 8'h00;
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        n_tests++; if (bus.out !== 8'hC3 || bus.out_valid !== 1'b1 || bus.carry !== 1'b0) begin n_fail++; $display("FAIL b2b_2 got %h/%b/%b exp C3/1/0", bus.out, bus.out_valid, bus.carry); end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul(input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_out, input logic exp_carry);
        int low_edges;
        int early_valid;
        int guard;
        low_edges = 0; early_valid = 0; guard = 0;
        do_op(OP_MUL, a, d);
        n_tests++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_start got busy %b valid %b exp 1/0", bus.busy, bus.out_valid); end
        // held request during busy must not be taken
        bus.in_valid = 1'b1; bus.opcode = OP_ADD; bus.accum = 8'h00; bus.data = 8'h01;
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            low_edges++;
            if (bus.out_valid === 1'b1) early_valid++;
            @(negedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        n_tests++; if (low_edges !== 9) begin n_fail++; $display("FAIL mul_latency got %0d exp 9", low_edges); end
        n_tests++; if (early_valid !== 0) begin n_fail++; $display("FAIL mul_early_valid got %0d exp 0", early_valid); end
        n_tests++; if (bus.out !== exp_out || bus.carry !== exp_carry || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_result got %h/%b/%b exp %h/%b/1", bus.out, bus.carry, bus.out_valid, exp_out, exp_carry); end
        n_tests++; if (bus.zero !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_flags got zero %b busy %b exp 0/0", bus.zero, bus.busy); end
        @(negedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out !== exp_out) begin n_fail++; $display("FAIL mul_held_op got %b/%h exp 0/%h", bus.out_valid, bus.out, exp_out); end
    endtask

    task automatic test_mul_reset();
        int seen_valid;
        seen_valid = 0;
        do_op(OP_MUL, 8'h0C, 8'h0B);
        repeat (3) begin @(negedge clk); #1; end
        rst_ = 1'b0;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out !== 8'h00) begin n_fail++; $display("FAIL mulrst got rdy %b busy %b valid %b out %h exp 1/0/0/00", bus.in_ready, bus.busy, bus.out_valid, bus.out); end
        @(negedge clk); #1;
        rst_ = 1'b1;
        repeat (12) begin
            @(negedge clk); #1;
            if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen_valid++;
        end
        n_tests++; if (seen_valid !== 0) begin n_fail++; $display("FAIL mulrst_after got %0d bad edges exp 0", seen_valid); end
    endtask
`else
    task automatic test_mul_disabled();
        do_op(OP_LDA, 8'h01, 8'h5A);
        do_op(OP_MUL, 8'h0C, 8'h0B);
        n_tests++; if (bus.out !== 8'h00 || bus.carry !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_undef got %h/%b/%b exp 00/0/1", bus.out, bus.carry, bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_undef_ready got %b/%b exp 1/0", bus.in_ready, bus.busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_sub();
        test_zero();
        test_logic_shift();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul(8'h0C, 8'h0B, 8'h84, 1'b0);
        test_mul(8'hFF, 8'h02, 8'hFE, 1'b1);
        test_mul(8'h37, 8'h00, 8'h00, 1'b0);
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
